dynamic_branch_predictor: RTL
=============================

DYNAMIC_BRANCH_PREDICTOR -- requirements
Module: dynamic_branch_predictor

Interface
REQ-001 SHALL have parameter ADDRESS_LEN, default 12: PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16: number of counter entries; power of two, at least 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_BITS, default 2: width of each saturating counter, at least 2.
REQ-004 SHALL have parameter STAT_W, default 16: width of each statistics counter.
REQ-005 SHALL have parameter BYPASS, default 1: 1 means the same-cycle update is forwarded to the lookup result.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port lookup_valid, input, 1 bit: the decode-stage instruction is a conditional branch.
REQ-009 SHALL have port lookup_pc, input, ADDRESS_LEN bits: PC of the decode-stage branch.
REQ-010 SHALL have port predict_taken, output, 1 bit: combinational prediction for lookup_pc.
REQ-011 SHALL have port update_valid, input, 1 bit: a branch resolved in the execute stage this cycle.
REQ-012 SHALL have port update_pc, input, ADDRESS_LEN bits: PC of the resolved branch.
REQ-013 SHALL have port update_taken, input, 1 bit: actual outcome of the resolved branch.
REQ-014 SHALL have port update_predicted, input, 1 bit: the prediction previously issued for that branch.
REQ-015 SHALL have port mispredict, output, 1 bit: combinational flag; drives the flushes of the IF/ID and ID/EX pipeline registers.
REQ-016 SHALL have port stat_lookups, output, STAT_W bits: registered count of valid lookups.
REQ-017 SHALL have port stat_mispredicts, output, STAT_W bits: registered count of mispredictions.

Function
REQ-018 SHALL form both indices from the low IDX_W PC bits (lookup_pc[IDX_W-1:0] and update_pc[IDX_W-1:0]); there are no tags, so aliasing PCs share an entry.
REQ-019 SHALL hold ENTRIES counters of CNT_BITS bits each; predict_taken SHALL equal the MSB of the indexed counter when lookup_valid=1, and 0 otherwise.
REQ-020 SHALL update the indexed counter at the clock edge when update_valid=1: +1 if update_taken=1, saturating at 2^CNT_BITS-1; -1 if update_taken=0, saturating at 0.
REQ-021 SHALL compute mispredict = update_valid AND (update_taken XOR update_predicted), with zero latency.
REQ-022 SHALL, with BYPASS=1 and lookup index equal to update index in the same cycle, derive predict_taken from the post-update counter value.
REQ-023 SHALL, with BYPASS=0 in the same case, derive predict_taken from the pre-update counter value.
REQ-024 SHALL increment stat_lookups by 1 per cycle with lookup_valid=1, saturating at 2^STAT_W-1 with no wrap.
REQ-025 SHALL increment stat_mispredicts by 1 per cycle with mispredict=1, saturating at 2^STAT_W-1 with no wrap.
REQ-026 SHALL make lookup and update independent: both may occur in the same cycle to any indices, and only one update per cycle is accepted.
REQ-027 SHALL leave all state unchanged when neither lookup_valid nor update_valid is asserted.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set every counter to 2^(CNT_BITS-1)-1 (weakly not-taken, 01 for CNT_BITS=2).
REQ-029 SHALL, on rst=1 at a clock edge, clear stat_lookups and stat_mispredicts to 0.
REQ-030 SHALL give rst priority over a simultaneous update, discarding that update and its statistics increments.
REQ-031 SHALL hold predict_taken=0 in the first cycle after reset for any lookup_pc.
REQ-032 SHALL keep mispredict purely combinational and unaffected by reset.

Verification
REQ-033 SHALL cover reset defaults: rst for 1 cycle, then lookup any PC -> predict_taken=0, stat_lookups=0, stat_mispredicts=0.
REQ-034 SHALL cover training and aliasing (ENTRIES=16): two taken updates at pc 0x005 -> lookups at 0x005 and 0x015 give predict_taken=1, lookup at 0x006 gives 0.
REQ-035 SHALL cover counter saturation: four taken updates at 0x003 -> counter 11; one not-taken -> 10, predicts 1; second not-taken -> 01, predicts 0; three more not-taken -> 00, stays at 00.
REQ-036 SHALL cover bypass: counter at 01, update taken and lookup at the same index in one cycle -> predict_taken=1 with BYPASS=1, 0 with BYPASS=0.
REQ-037 SHALL cover mispredict and saturation: update_taken=1 with update_predicted=0 -> mispredict=1 that cycle and stat_mispredicts +1 next cycle; with STAT_W=4, 20 mispredicts -> stat_mispredicts=15.
REQ-038 SHALL cover reset mid-operation: train 0x005 to 11, then assert rst together with a taken update -> counter 01 and stats 0 next cycle, update discarded.

Source files
------------

// File: rtl/dynamic_branch_predictor.sv
// Bimodal branch predictor: a PC-indexed table of saturating counters with
// optional same-cycle update forwarding, plus saturating lookup/mispredict statistics.
module dynamic_branch_predictor #(
  parameter int ADDRESS_LEN = 12,
  parameter int ENTRIES     = 16,
  parameter int CNT_BITS    = 2,
  parameter int STAT_W      = 16,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_valid,
  input  logic [ADDRESS_LEN-1:0] lookup_pc,
  output logic                   predict_taken,
  input  logic                   update_valid,
  input  logic [ADDRESS_LEN-1:0] update_pc,
  input  logic                   update_taken,
  input  logic                   update_predicted,
  output logic                   mispredict,
  output logic [STAT_W-1:0]      stat_lookups,
  output logic [STAT_W-1:0]      stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_MIN  = '0;
  localparam logic [CNT_BITS-1:0] CNT_INIT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [STAT_W-1:0]   STAT_MAX = {STAT_W{1'b1}};

  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_d [ENTRIES];
  logic [STAT_W-1:0]   lookups_q, lookups_d;
  logic [STAT_W-1:0]   mispredicts_q, mispredicts_d;

  logic [IDX_W-1:0]    lookup_idx;
  logic [IDX_W-1:0]    update_idx;
  logic [CNT_BITS-1:0] update_cnt_old;
  logic [CNT_BITS-1:0] update_cnt_new;
  logic [CNT_BITS-1:0] lookup_cnt;
  logic                unused_pc_bits;

  // No tags: only the low PC bits select an entry, so aliasing PCs share it.
  assign lookup_idx     = lookup_pc[IDX_W-1:0];
  assign update_idx     = update_pc[IDX_W-1:0];
  assign unused_pc_bits = ^{lookup_pc[ADDRESS_LEN-1:IDX_W], update_pc[ADDRESS_LEN-1:IDX_W]};

  assign mispredict = update_valid & (update_taken ^ update_predicted);

  always_comb begin
    update_cnt_old = cnt_q[update_idx];
    update_cnt_new = update_cnt_old;
    if (update_taken) begin
      if (update_cnt_old != CNT_MAX) update_cnt_new = update_cnt_old + 1'b1;
    end else begin
      if (update_cnt_old != CNT_MIN) update_cnt_new = update_cnt_old - 1'b1;
    end
  end

  // Forwarding lets a lookup see the counter value that this edge will write.
  always_comb begin
    lookup_cnt = cnt_q[lookup_idx];
    if (BYPASS && update_valid && (lookup_idx == update_idx)) lookup_cnt = update_cnt_new;
    predict_taken = lookup_valid & lookup_cnt[CNT_BITS-1];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (update_valid) cnt_d[update_idx] = update_cnt_new;
  end

  always_comb begin
    lookups_d     = lookups_q;
    mispredicts_d = mispredicts_q;
    if (lookup_valid && (lookups_q != STAT_MAX)) lookups_d = lookups_q + 1'b1;
    if (mispredict && (mispredicts_q != STAT_MAX)) mispredicts_d = mispredicts_q + 1'b1;
  end

  // Reset wins over any same-cycle update and its statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      lookups_q     <= lookups_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;

endmodule
